// File: rtl/led_ram_wr_arbiter.sv
// Purpose : write-port arbiter and full-frame clear sequencer for the 8x8 LED display RAM.
// Latency : pen write and pen_ack appear 1 cycle after a granted pen_req; a clear writes one cell per cycle.
// Backpress: pen_req is held until pen_ack; it waits while a clear owns the port (fixed priority).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   pen_req/pen_row/pen_col/pen_data -> pen_ack   light-pen write request and grant pulse
//   clr_start/clr_data -> clr_busy/clr_done       full-frame clear request, status and completion pulse
//   ram_we/ram_addr/ram_wdata      registered RAM write port, ram_addr = {row,col}
//
// Build option: define LED_RAM_ARB_RR_EN to interleave a pending pen write after each clear write
// instead of holding the pen off until the clear has finished.
module led_ram_wr_arbiter #(
  parameter int ROW_W   = 3,
  parameter int COL_W   = 3,
  parameter int DATA_W  = 4,
  parameter int CLR_LEN = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pen_req,
  input  logic [ROW_W-1:0]         pen_row,
  input  logic [COL_W-1:0]         pen_col,
  input  logic [DATA_W-1:0]        pen_data,
  output logic                     pen_ack,
  input  logic                     clr_start,
  input  logic [DATA_W-1:0]        clr_data,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     ram_we,
  output logic [ROW_W+COL_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]        ram_wdata
);

  localparam int ADDR_W = ROW_W + COL_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLR_LEN - 1);

  logic [1:0]        state, state_n;
  // Address of the most recent clear write; the next clear write goes to cnt+1.
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] fill, fill_n;

  logic              we_n, ack_n, done_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;

  // A pen grant is never issued while the previous grant's ack is still showing,
  // since the requester has not yet had a chance to drop pen_req.
  logic pen_ok;
  assign pen_ok = pen_req && !pen_ack;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fill_n  = fill;
    we_n    = 1'b0;
    ack_n   = 1'b0;
    done_n  = 1'b0;
    addr_n  = ram_addr;
    wdata_n = ram_wdata;

    case (state)
      S_IDLE: begin
        if (clr_start) begin
          // Clear wins over a simultaneous pen request; first cell is written right away.
          state_n = S_CLEAR;
          cnt_n   = '0;
          fill_n  = clr_data;
          we_n    = 1'b1;
          addr_n  = '0;
          wdata_n = clr_data;
        end else if (pen_ok) begin
          we_n    = 1'b1;
          ack_n   = 1'b1;
          addr_n  = {pen_row, pen_col};
          wdata_n = pen_data;
        end
      end

      S_CLEAR: begin
        // pen_ack high here means the current slot was an inserted pen write,
        // so cnt does not describe a write happening this cycle.
        if (!pen_ack && cnt == LAST_ADDR) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          if (pen_ok) begin
            we_n    = 1'b1;
            ack_n   = 1'b1;
            addr_n  = {pen_row, pen_col};
            wdata_n = pen_data;
          end
        end
`ifdef LED_RAM_ARB_RR_EN
        else if (pen_ok) begin
          we_n    = 1'b1;
          ack_n   = 1'b1;
          addr_n  = {pen_row, pen_col};
          wdata_n = pen_data;
        end
`endif
        else begin
          cnt_n   = cnt + 1'b1;
          we_n    = 1'b1;
          addr_n  = cnt + 1'b1;
          wdata_n = fill;
        end
      end

      S_DONE: begin
        // clr_start is ignored here; the pen may take the port immediately.
        state_n = S_IDLE;
        if (pen_ok) begin
          we_n    = 1'b1;
          ack_n   = 1'b1;
          addr_n  = {pen_row, pen_col};
          wdata_n = pen_data;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      fill      <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      pen_ack   <= 1'b0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      fill      <= fill_n;
      ram_we    <= we_n;
      ram_addr  <= addr_n;
      ram_wdata <= wdata_n;
      pen_ack   <= ack_n;
      clr_busy  <= (state_n == S_CLEAR);
      clr_done  <= done_n;
    end
  end

endmodule
